// File: rtl/draw_rect_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : draw_rect_ctl_if
// Description : Mouse-in / rectangle-position-out bundle for draw_rect_ctl.
//               master = mouse side / consumer, slave = position controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface draw_rect_ctl_if;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        falling;

  modport master (
    output mouse_xpos, mouse_ypos, mouse_left,
    input  xpos, ypos, falling
  );

  modport slave (
    input  mouse_xpos, mouse_ypos, mouse_left,
    output xpos, ypos, falling
  );
endinterface
`default_nettype wire

// File: rtl/draw_rect_ctl.sv
`default_nettype none
// ============================================================================
// Module      : draw_rect_ctl
// Description : Rectangle position controller. Follows the mouse (clamped to
//               keep the rectangle on screen) while idle; a left click drops
//               the rectangle under constant gravity until it reaches the
//               bottom edge. Optional bounce behaviour is enabled by defining
//               the macro DRAW_RECT_CTL_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_ctl #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int RECT_W   = 100,
  parameter int RECT_H   = 100,
  parameter int TICK_DIV = 650000,
  parameter int GRAV     = 1,
  parameter int VMAX     = 20
) (
  input  wire logic       clk,
  input  wire logic       rst,
  draw_rect_ctl_if.slave  bus
);

  localparam logic [12:0] c_XMAX = 13'(SCREEN_W - RECT_W);
  localparam logic [12:0] c_YMAX = 13'(SCREEN_H - RECT_H);
  localparam logic [12:0] c_GRAV = 13'(GRAV);
  localparam logic [12:0] c_VMAX = 13'(VMAX);
  localparam int          c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

`ifdef DRAW_RECT_CTL_BOUNCE_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FALL   = 2'd1,
    ST_LANDED = 2'd2,
    ST_RISE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FALL   = 2'd1,
    ST_LANDED = 2'd2
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [11:0]          xpos_q, xpos_d;
  logic [11:0]          ypos_q, ypos_d;
  logic                 falling_q, falling_d;
  logic [12:0]          vel_q, vel_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 mouse_left_q;

  logic                 w_click;
  logic                 w_tick;
  logic [11:0]          w_x_clamp;
  logic [11:0]          w_y_clamp;
  logic [12:0]          w_v_inc;
  logic [12:0]          w_v_next;
  logic [12:0]          w_y_sum;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
  logic [12:0]          w_y_rise;
`endif

  // Rising edge of the button only; a held button never re-triggers.
  assign w_click   = bus.mouse_left & ~mouse_left_q;
  assign w_tick    = (cnt_q == c_TICK_LAST);
  assign w_x_clamp = ({1'b0, bus.mouse_xpos} > c_XMAX) ? c_XMAX[11:0] : bus.mouse_xpos;
  assign w_y_clamp = ({1'b0, bus.mouse_ypos} > c_YMAX) ? c_YMAX[11:0] : bus.mouse_ypos;
  // Velocity after this tick's gravity step, saturated at VMAX.
  assign w_v_inc   = vel_q + c_GRAV;
  assign w_v_next  = (w_v_inc > c_VMAX) ? c_VMAX : w_v_inc;
  // 13-bit sum so a large step past the floor is seen as a landing, not a wrap.
  assign w_y_sum   = {1'b0, ypos_q} + w_v_next;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
  // Upward move clamped at the top edge.
  assign w_y_rise  = ({1'b0, ypos_q} > vel_q) ? ({1'b0, ypos_q} - vel_q) : 13'd0;
`endif

  // State register and all datapath flops; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      xpos_q       <= 12'd0;
      ypos_q       <= 12'd0;
      falling_q    <= 1'b0;
      vel_q        <= 13'd0;
      cnt_q        <= '0;
      mouse_left_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      falling_q    <= falling_d;
      vel_q        <= vel_d;
      cnt_q        <= cnt_d;
      mouse_left_q <= bus.mouse_left;
    end
  end

  // Next-state and datapath: tracking, gravity fall, landing (and bounce).
  always_comb begin
    state_d   = state_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    falling_d = falling_q;
    vel_d     = vel_q;
    cnt_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_click) begin
          // Position freezes at the registered value; this cycle's mouse
          // sample is deliberately dropped.
          state_d   = ST_FALL;
          falling_d = 1'b1;
          vel_d     = 13'd0;
        end else begin
          xpos_d = w_x_clamp;
          ypos_d = w_y_clamp;
        end
      end

      ST_FALL: begin
        cnt_d = w_tick ? '0 : (cnt_q + c_CNT_ONE);
        if (w_tick) begin
          vel_d = w_v_next;
          if (w_y_sum >= c_YMAX) begin
            ypos_d = c_YMAX[11:0];
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            if (w_v_next >= 13'd2) begin
              vel_d   = w_v_next >> 1;
              state_d = ST_RISE;
            end else begin
              vel_d     = 13'd0;
              state_d   = ST_LANDED;
              falling_d = 1'b0;
            end
`else
            vel_d     = 13'd0;
            state_d   = ST_LANDED;
            falling_d = 1'b0;
`endif
          end else begin
            ypos_d = w_y_sum[11:0];
          end
        end
      end

`ifdef DRAW_RECT_CTL_BOUNCE_EN
      ST_RISE: begin
        cnt_d = w_tick ? '0 : (cnt_q + c_CNT_ONE);
        if (w_tick) begin
          ypos_d = w_y_rise[11:0];
          if (vel_q <= c_GRAV) begin
            vel_d   = 13'd0;
            state_d = ST_FALL;
          end else begin
            vel_d = vel_q - c_GRAV;
          end
        end
      end
`endif

      ST_LANDED: begin
        if (w_click) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.xpos    = xpos_q;
  assign bus.ypos    = ypos_q;
  assign bus.falling = falling_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_rect_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_rect_ctl
// Description : Self-checking bench for draw_rect_ctl: behavioural model
//               compared every cycle plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_rect_ctl;

  localparam int TICK_DIV = 4;
  localparam int GRAV     = 1;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
  localparam int VMAX     = 20;
  localparam bit BOUNCE   = 1'b1;
`else
  localparam int VMAX     = 64;
  localparam bit BOUNCE   = 1'b0;
`endif
  localparam int XMAX = 800 - 100;
  localparam int YMAX = 600 - 100;
  localparam int LAND_LIMIT = 5000;

  localparam int M_IDLE = 0, M_FALL = 1, M_LANDED = 2, M_RISE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  always #5 clk = ~clk;

  draw_rect_ctl_if bus ();

  draw_rect_ctl #(
    .SCREEN_W (800),
    .SCREEN_H (600),
    .RECT_W   (100),
    .RECT_H   (100),
    .TICK_DIV (TICK_DIV),
    .GRAV     (GRAV),
    .VMAX     (VMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: physics expressed directly in pixels and ticks.
  typedef struct packed {
    int x;
    int y;
    int fall;
    int vel;
    int mode;
    int cyc;
    int prev_left;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, int mx, int my, int ml);
    model_t n;
    int     v;
    bit     click;
    n = s;
    click = (ml == 1) && (s.prev_left == 0);
    n.prev_left = ml;
    case (s.mode)
      M_IDLE: begin
        if (click) begin
          n.mode = M_FALL; n.fall = 1; n.vel = 0; n.cyc = 0;
        end else begin
          n.x = (mx < XMAX) ? mx : XMAX;
          n.y = (my < YMAX) ? my : YMAX;
        end
      end
      M_LANDED: begin
        if (click) n.mode = M_IDLE;
      end
      default: begin
        n.cyc = s.cyc + 1;
        if (n.cyc % TICK_DIV == 0) begin
          if (s.mode == M_FALL) begin
            v = s.vel + GRAV;
            if (v > VMAX) v = VMAX;
            if (s.y + v >= YMAX) begin
              n.y = YMAX;
              if (BOUNCE && v >= 2) begin
                n.vel = v / 2; n.mode = M_RISE;
              end else begin
                n.vel = 0; n.mode = M_LANDED; n.fall = 0;
              end
            end else begin
              n.y = s.y + v; n.vel = v;
            end
          end else begin
            n.y = (s.y > s.vel) ? s.y - s.vel : 0;
            if (s.vel <= GRAV) begin
              n.vel = 0; n.mode = M_FALL;
            end else begin
              n.vel = s.vel - GRAV;
            end
          end
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= step(m, int'(bus.mouse_xpos), int'(bus.mouse_ypos), int'(bus.mouse_left));
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_xpos",    32'(bus.xpos),    m.x);
      chk("model_ypos",    32'(bus.ypos),    m.y);
      chk("model_falling", 32'(bus.falling), m.fall);
    end
  end

  task automatic set_mouse(input int x, input int y);
    bus.mouse_xpos = 12'(x);
    bus.mouse_ypos = 12'(y);
  endtask

  task automatic click_pulse();
    @(negedge clk);
    bus.mouse_left = 1'b1;
    @(negedge clk);
    bus.mouse_left = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic wait_land(input string name);
    int n = 0;
    while (bus.falling === 1'b1 && n < LAND_LIMIT) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= LAND_LIMIT) begin
      n_fail++;
      $display("FAIL %s: still falling after %0d cycles, required landing", name, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tri_tab[4];
    tri_tab = '{1, 3, 6, 10};
    bus.mouse_left = 1'b0;
    set_mouse(300, 200);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // 1. Reset and release
    repeat (3) @(negedge clk);
    chk("rst_xpos", 32'(bus.xpos), 0);
    chk("rst_ypos", 32'(bus.ypos), 0);
    chk("rst_falling", 32'(bus.falling), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("track_x", 32'(bus.xpos), 300);
    chk("track_y", 32'(bus.ypos), 200);

    // 2. Clamping
    set_mouse(790, 580); @(negedge clk);
    chk("clamp_hi_x", 32'(bus.xpos), 700);
    chk("clamp_hi_y", 32'(bus.ypos), 500);
    set_mouse(700, 500); @(negedge clk);
    chk("clamp_eq_x", 32'(bus.xpos), 700);
    chk("clamp_eq_y", 32'(bus.ypos), 500);
    set_mouse(0, 0); @(negedge clk);
    chk("clamp_lo_x", 32'(bus.xpos), 0);
    chk("clamp_lo_y", 32'(bus.ypos), 0);

    // 3. Fall profile
    set_mouse(100, 0); @(negedge clk);
    click_pulse();
    chk("fall_start", 32'(bus.falling), 1);
    for (int k = 0; k < 4; k++) begin
      wait_ticks(1);
      chk("fall_tri", 32'(bus.ypos), tri_tab[k]);
      if (k == 1) set_mouse(400, 300);
    end
`ifndef DRAW_RECT_CTL_BOUNCE_EN
    wait_ticks(27);
    chk("fall_t31", 32'(bus.ypos), 496);
    chk("fall_t31_f", 32'(bus.falling), 1);
    wait_ticks(1);
    chk("fall_t32", 32'(bus.ypos), 500);
    chk("fall_t32_f", 32'(bus.falling), 0);
`else
    wait_land("fall_land");
`endif
    chk("fall_x_frozen", 32'(bus.xpos), 100);

    // 4. Clicks during fall ignored, held button through landing
    click_pulse();
    repeat (2) @(negedge clk);
    set_mouse(250, 0); @(negedge clk);
    chk("resume_x", 32'(bus.xpos), 250);
    click_pulse();
    wait_ticks(2);
    click_pulse();
    repeat (3) @(negedge clk);
    click_pulse();
    @(negedge clk);
    bus.mouse_left = 1'b1;
    wait_land("held_land");
    repeat (10) @(negedge clk);
    chk("held_landed_y", 32'(bus.ypos), 500);
    chk("held_landed_f", 32'(bus.falling), 0);
    chk("held_landed_x", 32'(bus.xpos), 250);
    bus.mouse_left = 1'b0;
    @(negedge clk);
    set_mouse(123, 45);
    click_pulse();
    @(negedge clk);
    chk("retrack_x", 32'(bus.xpos), 123);
    chk("retrack_y", 32'(bus.ypos), 45);

    // 5. Reset mid-fall
    set_mouse(200, 0); @(negedge clk);
    click_pulse();
    wait_ticks(9);
    chk("mid_y45", 32'(bus.ypos), 45);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_x", 32'(bus.xpos), 0);
    chk("mid_rst_y", 32'(bus.ypos), 0);
    chk("mid_rst_f", 32'(bus.falling), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    click_pulse();
    wait_ticks(1);
    chk("restart_vel0", 32'(bus.ypos), 1);
    wait_land("restart_land");

`ifdef DRAW_RECT_CTL_BOUNCE_EN
    // 6. Bounce sequence from ypos 0
    click_pulse();
    repeat (2) @(negedge clk);
    set_mouse(100, 0); @(negedge clk);
    click_pulse();
    wait_ticks(35);
    chk("bounce_impact_y", 32'(bus.ypos), 500);
    chk("bounce_impact_f", 32'(bus.falling), 1);
    wait_ticks(1);
    chk("bounce_r1", 32'(bus.ypos), 490);
    wait_ticks(1);
    chk("bounce_r2", 32'(bus.ypos), 481);
    wait_land("bounce_land");
    chk("bounce_final_y", 32'(bus.ypos), 500);
    chk("bounce_final_f", 32'(bus.falling), 0);
`endif

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
